mcht_link_sched: RTL and testbench
==================================

// Module: mcht_link_sched
// PURPOSE
//  Half-duplex Manchester link scheduler: shares one encoder among pNREQ local requesters (round-robin).
//  Per transaction: send request word, turn the line around, wait for the decoder's response word or a timeout.
//  Sits between requester logic and the encoder/decoder pair; CLK100M domain only.
// PARAMETERS
//  pNREQ     4     number of requesters (2..8)
//  pMSG_LEN  16    message width, matches encoder/decoder
//  pTURN     32    turnaround guard, CLK100M cycles between encoder idle and response window
//  pRSP_TO   4096  response timeout, CLK100M cycles from window open
// PORTS
//  CLK100M  in   1                 100MHz clock
//  RST_N    in   1                 reset, asynchronous, active-low
//  REQ      in   pNREQ             per-requester request level; hold until RSP_DONE for that requester
//  REQ_MSG  in   pNREQ*pMSG_LEN    packed request words, requester i at [i*pMSG_LEN +: pMSG_LEN]
//  GNT      out  pNREQ             one-hot grant, held for whole transaction
//  RSP_MSG  out  pMSG_LEN          response word, valid when RSP_DONE & ~RSP_TO
//  RSP_DONE out  1                 1-cycle pulse, transaction finished (to granted requester)
//  RSP_TO   out  1                 1-cycle pulse with RSP_DONE when timed out
//  ENC_MSG  out  pMSG_LEN          word to encoder, stable from ENC_START until ENC_BUSY falls
//  ENC_START out 1                 1-cycle encoder start pulse
//  ENC_BUSY in   1                 encoder transmitting
//  DEC_MSG  in   pMSG_LEN          decoder output word
//  DEC_VLD  in   1                 decoder valid level (CLK_25M domain, held until line idle)
// BEHAVIOUR
//  Reset: GNT=0, ENC_START=0, ENC_MSG=0, RSP_MSG=0, RSP_DONE=0, RSP_TO=0, rr_ptr=0, state=eIDLE.
//  DEC_VLD: 2-flop synchroniser then rising-edge detect -> dec_new (1 cycle). DEC_MSG sampled on dec_new.
//  FSM:
//   eIDLE    : |REQ -> eGRANT; pick first set REQ at or after rr_ptr (wrap at pNREQ); GNT registered.
//   eGRANT   : ENC_MSG <= granted word; -> eSTART.
//   eSTART   : ENC_START=1 for exactly 1 cycle; -> eW4_BUSY.
//   eW4_BUSY : wait ENC_BUSY=1 (max 8 cycles, else treat as done) -> eW4_TX.
//   eW4_TX   : ENC_BUSY=0 -> eTURN, load turn counter pTURN-1.
//   eTURN    : count down; at 0 -> eW4_RSP, load timeout counter pRSP_TO-1.
//   eW4_RSP  : dec_new -> capture RSP_MSG, -> eDONE(ok); counter 0 without dec_new -> eDONE(to).
//   eDONE    : RSP_DONE=1, RSP_TO per outcome, GNT cleared same cycle's edge; rr_ptr <= granted idx+1 (wrap);
//              -> eIDLE. Earliest next grant 1 cycle after eDONE.
//  Latency: REQ to ENC_START = 3 cycles from eIDLE. Response to RSP_DONE = sync(2)+edge(1)+1 cycles.
//  Boundaries:
//   - dec_new and timeout expiry in same cycle: response wins, RSP_TO=0.
//   - dec_new in any state other than eW4_RSP: ignored (echo/stale word), RSP_MSG unchanged.
//   - DEC_VLD already high entering eW4_RSP: no edge, not accepted; wait for new rising edge.
//   - REQ of granted requester dropped mid-transaction: transaction still completes; RSP_DONE still issued.
//   - REQ changes in other lanes during transaction: no effect until eIDLE.
//   - all REQ set: strict rotation, each served once per pNREQ transactions.
//   - counters saturate at 0; widths $clog2(pTURN), $clog2(pRSP_TO).
//   - RST_N asserted mid-operation: immediate return to reset values; ENC_START never glitches high.
// STRUCTURE
//  Package mcht_pkg: state enum type, MCHT_MSG_LEN default, turnaround/timeout defaults.
//  Sub-module mcht_rr_arb (pNREQ): rr_ptr + REQ -> one-hot grant and index, combinational pick.
//  Synchroniser/edge detect, counters and FSM inline.
// TESTING
//  1 REQ=4'b0001, word 16'hA5C3, response 16'h1234 after TX -> ENC_START 1 cycle, ENC_MSG=A5C3, RSP_MSG=1234, RSP_TO=0.
//  2 REQ=4'b1111 held -> grant order 0,1,2,3,0; each GNT one-hot, no overlap between transactions.
//  3 No response -> RSP_DONE+RSP_TO exactly pRSP_TO cycles after eW4_RSP entry, RSP_MSG unchanged.
//  4 DEC_VLD pulse during eW4_TX/eTURN (echo) -> ignored; later real response accepted.
//  5 Response edge coincides with timeout expiry -> RSP_TO=0, RSP_MSG captured.
//  6 RST_N low during eW4_RSP -> all outputs reset values next cycle; new REQ afterwards served from rr_ptr=0.

Source files
------------

// File: rtl/mcht_pkg.sv
// Shared types and defaults for the half-duplex Manchester link scheduler.
//   mcht_state_e   : scheduler FSM states (also exported for debug)
//   MCHT_*         : default message width, requester count, turnaround
//                    guard, response timeout and encoder-busy wait limit
package mcht_pkg;

  localparam int MCHT_MSG_LEN  = 16;
  localparam int MCHT_NREQ     = 4;
  localparam int MCHT_TURN     = 32;
  localparam int MCHT_RSP_TO   = 4096;
  // Cycles to wait for the encoder to raise ENC_BUSY before assuming it
  // already finished (very short frame or missed busy).
  localparam int MCHT_BUSY_MAX = 8;

  typedef enum logic [2:0] {
    eIDLE    = 3'd0,
    eGRANT   = 3'd1,
    eSTART   = 3'd2,
    eW4_BUSY = 3'd3,
    eW4_TX   = 3'd4,
    eTURN    = 3'd5,
    eW4_RSP  = 3'd6,
    eDONE    = 3'd7
  } mcht_state_e;

endpackage

// File: rtl/mcht_link_sched_if.sv
// Bundle of all non-clock signals of mcht_link_sched.
//   slave  : scheduler view (drives GNT, RSP_*, ENC_MSG, ENC_START, dbg_state)
//   master : environment view (requesters, encoder, decoder)
//
// Handshake summary:
//   - Requester i raises REQ[i] (level) with its word on REQ_MSG and holds it
//     until it sees RSP_DONE while GNT[i] is high. GNT is one-hot and stays
//     high for the whole transaction, including the RSP_DONE cycle.
//   - RSP_DONE is a single-cycle pulse; RSP_TO qualifies it (timeout), and
//     RSP_MSG is meaningful only when RSP_DONE & ~RSP_TO.
//   - ENC_START is a single-cycle pulse; ENC_MSG stays stable until the
//     encoder drops ENC_BUSY. DEC_VLD is an asynchronous level whose rising
//     edge marks a new DEC_MSG.
interface mcht_link_sched_if
  import mcht_pkg::*;
#(
  parameter int pNREQ    = MCHT_NREQ,
  parameter int pMSG_LEN = MCHT_MSG_LEN
);
  logic [pNREQ-1:0]          REQ;
  logic [pNREQ*pMSG_LEN-1:0] REQ_MSG;
  logic [pNREQ-1:0]          GNT;
  logic [pMSG_LEN-1:0]       RSP_MSG;
  logic                      RSP_DONE;
  logic                      RSP_TO;
  logic [pMSG_LEN-1:0]       ENC_MSG;
  logic                      ENC_START;
  logic                      ENC_BUSY;
  logic [pMSG_LEN-1:0]       DEC_MSG;
  logic                      DEC_VLD;
  mcht_state_e               dbg_state;

  modport slave (
    input  REQ, REQ_MSG, ENC_BUSY, DEC_MSG, DEC_VLD,
    output GNT, RSP_MSG, RSP_DONE, RSP_TO, ENC_MSG, ENC_START, dbg_state
  );

  modport master (
    output REQ, REQ_MSG, ENC_BUSY, DEC_MSG, DEC_VLD,
    input  GNT, RSP_MSG, RSP_DONE, RSP_TO, ENC_MSG, ENC_START, dbg_state
  );
endinterface

// File: rtl/mcht_rr_arb.sv
// Combinational round-robin pick.
//   rr_ptr : lane with highest priority this round
//   req    : request levels
//   gnt    : one-hot grant of the first set request at or after rr_ptr
//   idx    : binary index of that lane
//   any    : at least one request set
module mcht_rr_arb #(
  parameter int pNREQ = 4,
  localparam int IW   = $clog2(pNREQ)
) (
  input  logic [IW-1:0]    rr_ptr,
  input  logic [pNREQ-1:0] req,
  output logic [pNREQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  // One extra bit so rr_ptr + k never overflows before the wrap subtract.
  localparam int SW = IW + 1;

  logic [SW-1:0] lane;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    lane = '0;
    for (int k = 0; k < pNREQ; k++) begin
      lane = {1'b0, rr_ptr} + SW'(k);
      if (lane >= SW'(pNREQ)) lane = lane - SW'(pNREQ);
      if (!any && req[lane[IW-1:0]]) begin
        any = 1'b1;
        idx = lane[IW-1:0];
      end
    end
    gnt = any ? (pNREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/mcht_link_sched.sv
// Half-duplex Manchester link scheduler. Shares one encoder among pNREQ
// requesters in round-robin order; per transaction it sends the request
// word, waits out the line turnaround, then waits for the decoder's
// response word or a timeout.
//   CLK100M, RST_N : clock, asynchronous active-low reset
//   bus (slave)    : requester, encoder and decoder signals plus dbg_state
module mcht_link_sched
  import mcht_pkg::*;
#(
  parameter int pNREQ    = MCHT_NREQ,
  parameter int pMSG_LEN = MCHT_MSG_LEN,
  parameter int pTURN    = MCHT_TURN,
  parameter int pRSP_TO  = MCHT_RSP_TO
) (
  input logic              CLK100M,
  input logic              RST_N,
  mcht_link_sched_if.slave bus
);
  localparam int IW = $clog2(pNREQ);
  localparam int TW = $clog2(pTURN);
  localparam int OW = $clog2(pRSP_TO);

  mcht_state_e         state, nxt;
  logic [pNREQ-1:0]    gnt_q, arb_gnt;
  logic [IW-1:0]       idx_q, rr_ptr, arb_idx;
  logic                arb_any;
  logic [pMSG_LEN-1:0] enc_msg_q, rsp_msg_q;
  logic                enc_start_q, rsp_done_q, rsp_to_q;
  logic                enc_start_d, rsp_done_d, rsp_to_d, rsp_cap;
  logic [2:0]          busy_cnt;
  logic [TW-1:0]       turn_cnt;
  logic [OW-1:0]       to_cnt;
  logic                dec_s1, dec_s2, dec_s3, dec_new;

  mcht_rr_arb #(.pNREQ(pNREQ)) u_arb (
    .rr_ptr (rr_ptr),
    .req    (bus.REQ),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // DEC_VLD crosses from the decoder clock: two sync flops, then a
  // registered rising-edge detect so a held level is only seen once.
  always_ff @(posedge CLK100M or negedge RST_N) begin
    if (!RST_N) begin
      dec_s1  <= 1'b0;
      dec_s2  <= 1'b0;
      dec_s3  <= 1'b0;
      dec_new <= 1'b0;
    end else begin
      dec_s1  <= bus.DEC_VLD;
      dec_s2  <= dec_s1;
      dec_s3  <= dec_s2;
      dec_new <= dec_s2 & ~dec_s3;
    end
  end

  // State register
  always_ff @(posedge CLK100M or negedge RST_N) begin
    if (!RST_N) state <= eIDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      eIDLE:    if (arb_any) nxt = eGRANT;
      eGRANT:   nxt = eSTART;
      eSTART:   nxt = eW4_BUSY;
      eW4_BUSY: begin
        if (bus.ENC_BUSY)                           nxt = eW4_TX;
        else if (busy_cnt == 3'(MCHT_BUSY_MAX - 1)) nxt = eTURN;
      end
      eW4_TX:   if (!bus.ENC_BUSY) nxt = eTURN;
      eTURN:    if (turn_cnt == '0) nxt = eW4_RSP;
      // A response arriving on the last timeout cycle still counts.
      eW4_RSP:  if (dec_new || to_cnt == '0) nxt = eDONE;
      eDONE:    nxt = eIDLE;
      default:  nxt = eIDLE;
    endcase
  end

  // Output decode. Strobes are decoded from the next state and registered,
  // so ENC_START/RSP_DONE/RSP_TO come straight from flops.
  always_comb begin
    enc_start_d = (nxt == eSTART);
    rsp_done_d  = (nxt == eDONE);
    rsp_cap     = (state == eW4_RSP) && dec_new;
    rsp_to_d    = (state == eW4_RSP) && (nxt == eDONE) && !dec_new;
  end

  // Datapath: grant, words, counters, strobes
  always_ff @(posedge CLK100M or negedge RST_N) begin
    if (!RST_N) begin
      gnt_q       <= '0;
      idx_q       <= '0;
      rr_ptr      <= '0;
      enc_msg_q   <= '0;
      rsp_msg_q   <= '0;
      enc_start_q <= 1'b0;
      rsp_done_q  <= 1'b0;
      rsp_to_q    <= 1'b0;
      busy_cnt    <= '0;
      turn_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      enc_start_q <= enc_start_d;
      rsp_done_q  <= rsp_done_d;
      rsp_to_q    <= rsp_to_d;
      if (rsp_cap) rsp_msg_q <= bus.DEC_MSG;

      if (state == eIDLE && arb_any) begin
        gnt_q <= arb_gnt;
        idx_q <= arb_idx;
      end
      if (state == eGRANT) enc_msg_q <= bus.REQ_MSG[idx_q*pMSG_LEN +: pMSG_LEN];
      if (state == eSTART)    busy_cnt <= '0;
      if (state == eW4_BUSY)  busy_cnt <= busy_cnt + 3'd1;
      if (state == eDONE) begin
        gnt_q  <= '0;
        rr_ptr <= (idx_q == IW'(pNREQ - 1)) ? '0 : idx_q + IW'(1);
      end

      if (state != eTURN && nxt == eTURN)            turn_cnt <= TW'(pTURN - 1);
      else if (state == eTURN && turn_cnt != '0)     turn_cnt <= turn_cnt - TW'(1);

      if (state != eW4_RSP && nxt == eW4_RSP)        to_cnt <= OW'(pRSP_TO - 1);
      else if (state == eW4_RSP && to_cnt != '0)     to_cnt <= to_cnt - OW'(1);
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.ENC_MSG   = enc_msg_q;
  assign bus.ENC_START = enc_start_q;
  assign bus.RSP_MSG   = rsp_msg_q;
  assign bus.RSP_DONE  = rsp_done_q;
  assign bus.RSP_TO    = rsp_to_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_mcht_link_sched.sv
// Directed testbench for mcht_link_sched with a short turnaround (8) and
// timeout (64). Inputs are driven and outputs checked on the falling edge.
module tb_mcht_link_sched;
  import mcht_pkg::*;

  localparam int NREQ = 4;
  localparam int MLEN = 16;
  localparam int TURN = 8;
  localparam int RTO  = 64;

  logic CLK100M;
  logic RST_N;
  int   n_vec;
  int   n_err;
  logic [MLEN-1:0] lane_word [NREQ];
  logic [31:0]     exp_q[$];

  mcht_link_sched_if #(.pNREQ(NREQ), .pMSG_LEN(MLEN)) bus ();

  mcht_link_sched #(
    .pNREQ(NREQ), .pMSG_LEN(MLEN), .pTURN(TURN), .pRSP_TO(RTO)
  ) dut (
    .CLK100M (CLK100M),
    .RST_N   (RST_N),
    .bus     (bus)
  );

  // Clock / reset block
  initial CLK100M = 1'b0;
  always #5 CLK100M = ~CLK100M;

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLK100M);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called with REQ already applied in eIDLE; ends one cycle after ENC_START.
  task automatic txn_front(input logic [NREQ-1:0] exp_gnt, input logic [MLEN-1:0] exp_word);
    step();
    chk("gnt", 32'(bus.GNT), 32'(exp_gnt));
    chk("start_pre", 32'(bus.ENC_START), 32'd0);
    step();
    chk("start", 32'(bus.ENC_START), 32'd1);
    chk("enc_msg", 32'(bus.ENC_MSG), 32'(exp_word));
    step();
    chk("start_post", 32'(bus.ENC_START), 32'd0);
  endtask

  // Encoder busy for 4 cycles, optional decoder echo during transmit,
  // then turnaround; ends on the first cycle of the response window.
  task automatic tx_and_turn(input bit echo, input logic [MLEN-1:0] prev_rsp);
    bus.ENC_BUSY = 1'b1;
    if (echo) begin
      bus.DEC_MSG = 16'hEEEE;
      bus.DEC_VLD = 1'b1;
    end
    step(4);
    bus.ENC_BUSY = 1'b0;
    bus.DEC_VLD  = 1'b0;
    step(1 + TURN);
    chk("rsp_done_early", 32'(bus.RSP_DONE), 32'd0);
    chk("rsp_msg_kept", 32'(bus.RSP_MSG), 32'(prev_rsp));
  endtask

  task automatic finish_txn(input logic [NREQ-1:0] exp_gnt, input logic exp_to,
                            input logic [MLEN-1:0] exp_msg);
    chk("done", 32'(bus.RSP_DONE), 32'd1);
    chk("to", 32'(bus.RSP_TO), 32'(exp_to));
    chk("rsp_msg", 32'(bus.RSP_MSG), 32'(exp_msg));
    chk("gnt_hold", 32'(bus.GNT), 32'(exp_gnt));
    bus.DEC_VLD = 1'b0;
    step();
    chk("done_clr", 32'(bus.RSP_DONE), 32'd0);
    chk("to_clr", 32'(bus.RSP_TO), 32'd0);
    chk("gnt_clr", 32'(bus.GNT), 32'd0);
  endtask

  // Decoder rises at window open: sync(2) + edge(1) + 1 cycles to RSP_DONE.
  task automatic respond(input logic [MLEN-1:0] msg, input logic [NREQ-1:0] exp_gnt);
    bus.DEC_MSG = msg;
    bus.DEC_VLD = 1'b1;
    step(3);
    chk("done_latency", 32'(bus.RSP_DONE), 32'd0);
    step();
    finish_txn(exp_gnt, 1'b0, msg);
  endtask

  task automatic set_words();
    bus.REQ_MSG = {lane_word[3], lane_word[2], lane_word[1], lane_word[0]};
  endtask

  initial begin
    logic [31:0] lane;
    n_vec = 0;
    n_err = 0;
    RST_N        = 1'b0;
    bus.REQ      = '0;
    bus.REQ_MSG  = '0;
    bus.ENC_BUSY = 1'b0;
    bus.DEC_MSG  = '0;
    bus.DEC_VLD  = 1'b0;

    // Reset state
    step(3);
    chk("rst_gnt", 32'(bus.GNT), 32'd0);
    chk("rst_start", 32'(bus.ENC_START), 32'd0);
    chk("rst_enc_msg", 32'(bus.ENC_MSG), 32'd0);
    chk("rst_rsp_msg", 32'(bus.RSP_MSG), 32'd0);
    chk("rst_done", 32'(bus.RSP_DONE), 32'd0);
    chk("rst_to", 32'(bus.RSP_TO), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(eIDLE));
    RST_N = 1'b1;
    step(2);

    // All requesters held: strict rotation 0,1,2,3,0
    lane_word[0] = 16'hA0A0; lane_word[1] = 16'hB1B1;
    lane_word[2] = 16'hC2C2; lane_word[3] = 16'hD3D3;
    set_words();
    exp_q = '{0, 1, 2, 3, 0};
    bus.REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      lane = exp_q.pop_front();
      txn_front(4'(1 << lane), lane_word[lane[1:0]]);
      tx_and_turn(1'b0, (k == 0) ? 16'h0000 : 16'(16'h5000 + k - 1));
      respond(16'(16'h5000 + k), 4'(1 << lane));
    end
    bus.REQ = '0;

    // Single requester, request dropped mid-transaction (rr_ptr=1 wraps to 0)
    lane_word[0] = 16'hA5C3;
    set_words();
    bus.REQ = 4'b0001;
    txn_front(4'b0001, 16'hA5C3);
    bus.REQ = 4'b0000;
    tx_and_turn(1'b0, 16'h5004);
    respond(16'h1234, 4'b0001);

    // No response: timeout exactly RTO cycles after window entry; other
    // lane rising mid-transaction must not disturb the grant.
    lane_word[1] = 16'h0F0F;
    set_words();
    bus.REQ = 4'b0010;
    txn_front(4'b0010, 16'h0F0F);
    bus.REQ = 4'b0011;
    tx_and_turn(1'b0, 16'h1234);
    step(RTO - 1);
    chk("to_early", 32'(bus.RSP_DONE), 32'd0);
    step();
    finish_txn(4'b0010, 1'b1, 16'h1234);
    bus.REQ = '0;

    // Echo during transmit ignored, later response accepted
    lane_word[2] = 16'h3C3C;
    set_words();
    bus.REQ = 4'b0100;
    txn_front(4'b0100, 16'h3C3C);
    tx_and_turn(1'b1, 16'h1234);
    respond(16'h4444, 4'b0100);
    bus.REQ = '0;

    // Response edge lands on the timeout-expiry cycle: response wins
    lane_word[3] = 16'h9696;
    set_words();
    bus.REQ = 4'b1000;
    txn_front(4'b1000, 16'h9696);
    tx_and_turn(1'b0, 16'h4444);
    step(RTO - 4);
    bus.DEC_MSG = 16'h7777;
    bus.DEC_VLD = 1'b1;
    step(3);
    chk("tie_early", 32'(bus.RSP_DONE), 32'd0);
    step();
    finish_txn(4'b1000, 1'b0, 16'h7777);
    bus.REQ = '0;

    // Move rr_ptr to 2, then reset inside the response window
    lane_word[1] = 16'h2222;
    set_words();
    bus.REQ = 4'b0010;
    txn_front(4'b0010, 16'h2222);
    bus.REQ = '0;
    tx_and_turn(1'b0, 16'h7777);
    respond(16'h6666, 4'b0010);

    lane_word[2] = 16'h3333;
    set_words();
    bus.REQ = 4'b0100;
    txn_front(4'b0100, 16'h3333);
    tx_and_turn(1'b0, 16'h6666);
    step(3);
    RST_N = 1'b0;
    #1;
    chk("arst_gnt", 32'(bus.GNT), 32'd0);
    chk("arst_start", 32'(bus.ENC_START), 32'd0);
    chk("arst_enc_msg", 32'(bus.ENC_MSG), 32'd0);
    chk("arst_rsp_msg", 32'(bus.RSP_MSG), 32'd0);
    chk("arst_done", 32'(bus.RSP_DONE), 32'd0);
    chk("arst_to", 32'(bus.RSP_TO), 32'd0);
    step();
    chk("arst_state", 32'(bus.dbg_state), 32'(eIDLE));
    RST_N = 1'b1;

    // After reset rr_ptr is 0 again: all requesting, lane 0 wins
    lane_word[0] = 16'hA0A0; lane_word[1] = 16'hB1B1;
    lane_word[2] = 16'hC2C2; lane_word[3] = 16'hD3D3;
    set_words();
    bus.REQ = 4'b1111;
    txn_front(4'b0001, 16'hA0A0);
    bus.REQ = '0;
    tx_and_turn(1'b0, 16'h0000);
    respond(16'h8888, 4'b0001);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
